// File: rtl/seq_gen_pkg.sv
// Shared constants, sel encoding, FSM state type and pattern helpers for seq_gen.
package seq_gen_pkg;

  localparam logic [3:0] PAT_X = 4'b1010;
  localparam logic [2:0] PAT_Y = 3'b111;
  localparam logic [1:0] PAT_Z = 2'b10;

  localparam int LEN_X   = 4;
  localparam int LEN_Y   = 3;
  localparam int LEN_Z   = 2;
  localparam int LEN_ALL = 4;

  localparam logic [1:0] SEL_X   = 2'd0;
  localparam logic [1:0] SEL_Y   = 2'd1;
  localparam logic [1:0] SEL_Z   = 2'd2;
  localparam logic [1:0] SEL_ALL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_e;

  // Per-lane load words, left-aligned in a 4-bit shift register.
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } lane_load_t;

  // Index of the last pattern bit for a given sel (pattern length - 1).
  function automatic logic [1:0] pat_last(input logic [1:0] sel);
    logic [1:0] last;
    last = 2'(LEN_ALL - 1);
    case (sel)
      SEL_X:   last = 2'(LEN_X - 1);
      SEL_Y:   last = 2'(LEN_Y - 1);
      SEL_Z:   last = 2'(LEN_Z - 1);
      default: last = 2'(LEN_ALL - 1);
    endcase
    return last;
  endfunction

  // Unselected lanes load zero so they stay quiet for the whole burst.
  function automatic lane_load_t lane_loads(input logic [1:0] sel);
    lane_load_t v;
    v.x = ((sel == SEL_X) || (sel == SEL_ALL)) ? PAT_X : 4'b0000;
    v.y = ((sel == SEL_Y) || (sel == SEL_ALL)) ? {PAT_Y, 1'b0} : 4'b0000;
    v.z = ((sel == SEL_Z) || (sel == SEL_ALL)) ? {PAT_Z, 2'b00} : 4'b0000;
    return v;
  endfunction

endpackage

// File: rtl/seq_gen_lane.sv
// One serial lane: loadable 4-bit MSB-first shift register with synchronous clear.
module seq_gen_lane
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       shift,
  output logic       q
);

  logic [3:0] sr;

  // Shifting in zeros means the lane falls silent on its own once the
  // pattern has been emitted, which covers the gap cycles for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= 4'b0000;
    end else if (clear) begin
      sr <= 4'b0000;
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      sr <= {sr[2:0], 1'b0};
    end
  end

  assign q = sr[3];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern burst generator; optional expect pulse under SEQ_GEN_EXPECT_EN.
// Handshake: start is accepted on any rising edge where start=1 and busy=0; busy then covers the whole burst.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             busy,
  output logic             done,
`ifdef SEQ_GEN_EXPECT_EN
  output logic             expect_flag,
`endif
  output seq_state_e       state
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [1:0]       sel_l;
  logic [CNT_W-1:0] reps_l;
  logic [CNT_W-1:0] rep_cnt;
  logic [1:0]       bit_cnt;
  logic [1:0]       last_idx;
  logic [3:0]       gap_cnt;

  logic       accept;
  logic       in_burst;
  logic       last_bit;
  logic       last_rep;
  logic       gap_end;
  logic       lane_clear;
  logic       lane_load;
  logic       lane_shift;
  logic [1:0] load_sel;
  lane_load_t load_vals;

  always_comb begin
    accept     = (state == ST_IDLE) && start;
    in_burst   = (state != ST_IDLE);
    last_bit   = (state == ST_SHIFT) && (bit_cnt == last_idx);
    last_rep   = (rep_cnt == reps_l);
    gap_end    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    lane_clear = in_burst && (abort || (last_bit && last_rep));
    lane_load  = !lane_clear && (accept || gap_end);
    lane_shift = !lane_clear && (state == ST_SHIFT);
    load_sel   = accept ? sel : sel_l;
    load_vals  = lane_loads(load_sel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_l    <= 2'd0;
      reps_l   <= '0;
      rep_cnt  <= '0;
      bit_cnt  <= 2'd0;
      last_idx <= 2'd0;
      gap_cnt  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_l    <= sel;
            reps_l   <= (reps == '0) ? CNT_W'(1) : reps;
            last_idx <= pat_last(sel);
            bit_cnt  <= 2'd0;
            rep_cnt  <= CNT_W'(1);
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (bit_cnt == last_idx) begin
            if (rep_cnt == reps_l) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              gap_cnt <= 4'd0;
              state   <= ST_GAP;
            end
          end else begin
            bit_cnt <= bit_cnt + 2'd1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            bit_cnt <= 2'd0;
            rep_cnt <= (rep_cnt == '1) ? rep_cnt : rep_cnt + CNT_W'(1);
            state   <= ST_SHIFT;
          end else begin
            gap_cnt <= (gap_cnt == 4'hF) ? gap_cnt : gap_cnt + 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  seq_gen_lane u_lane_x (
    .clk      (clk),
    .reset    (reset),
    .clear    (lane_clear),
    .load     (lane_load),
    .load_val (load_vals.x),
    .shift    (lane_shift),
    .q        (x)
  );

  seq_gen_lane u_lane_y (
    .clk      (clk),
    .reset    (reset),
    .clear    (lane_clear),
    .load     (lane_load),
    .load_val (load_vals.y),
    .shift    (lane_shift),
    .q        (y)
  );

  seq_gen_lane u_lane_z (
    .clk      (clk),
    .reset    (reset),
    .clear    (lane_clear),
    .load     (lane_load),
    .load_val (load_vals.z),
    .shift    (lane_shift),
    .q        (z)
  );

`ifdef SEQ_GEN_EXPECT_EN
  // Two-stage delay from the final pattern bit of each completed repetition.
  logic last_d1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d1     <= 1'b0;
      expect_flag <= 1'b0;
    end else begin
      last_d1     <= last_bit && !abort;
      expect_flag <= last_d1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed scoreboard bench for seq_gen (expect lane checked when SEQ_GEN_EXPECT_EN is defined).
module tb_seq_gen;
  import seq_gen_pkg::*;

  localparam int W = 6;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] sel;
  logic [3:0] reps;
  logic       abort;
  logic       x, y, z, busy, done;
  logic       exp_act;
  seq_state_e state;

  seq_gen #(.GAP_CYCLES(2), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sel         (sel),
    .reps        (reps),
    .abort       (abort),
    .x           (x),
    .y           (y),
    .z           (z),
    .busy        (busy),
    .done        (done),
`ifdef SEQ_GEN_EXPECT_EN
    .expect_flag (exp_act),
`endif
    .state       (state)
  );

`ifndef SEQ_GEN_EXPECT_EN
  assign exp_act = 1'b0;
`endif

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  string        tag;
  int           checks = 0;
  int           fails  = 0;
  logic         m1 = 1'b0;
  logic         m2 = 1'b0;

  // Monitor: one expected vector per cycle, {x,y,z,busy,done,expect}
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {x, y, z, busy, done, exp_act};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s @%0t: got xyz_busy_done_exp=%b want %b", t, $time, a, e);
        end
      end
    end
  end

  // Drive inputs for one cycle and queue the output expected after the next edge.
  // mk marks an output cycle carrying the final bit of a repetition.
  task automatic step(input logic s, input logic [1:0] sl, input logic [3:0] r,
                      input logic ab, input logic [4:0] v, input logic mk);
    logic e;
    start = s;
    sel   = sl;
    reps  = r;
    abort = ab;
    e  = m2;
    m2 = m1;
    m1 = mk;
`ifndef SEQ_GEN_EXPECT_EN
    e = 1'b0;
`endif
    exp_q.push_back({v, e});
    tag_q.push_back(tag);
    @(negedge clk);
    #1;
  endtask

  // Full burst: lane streams MSB-first over n busy cycles, then the done cycle.
  // sel/reps are scrambled while busy to show they are ignored mid-burst.
  task automatic burst(input logic [1:0] s, input logic [3:0] r,
                       input logic [15:0] xs, input logic [15:0] ys,
                       input logic [15:0] zs, input logic [15:0] lm,
                       input int n, input logic hold);
    int b;
    for (int i = 0; i < n; i++) begin
      b = n - 1 - i;
      step((i == 0) ? 1'b1 : hold, (i == 0) ? s : ~s, (i == 0) ? r : r + 4'd5,
           1'b0, {xs[b], ys[b], zs[b], 1'b1, 1'b0}, lm[b]);
    end
    step(hold, ~s, r + 4'd5, 1'b0, 5'b00001, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 1'b0, 5'b00000, 1'b0);
  endtask

  task automatic check_now(input string t);
    checks++;
    if ({x, y, z, busy, done, exp_act} !== '0 || state !== ST_IDLE) begin
      fails++;
      $display("FAIL %s: got xyz_busy_done_exp=%b state=%0d want 000000 state=0",
               t, {x, y, z, busy, done, exp_act}, state);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    sel   = 2'd0;
    reps  = 4'd0;
    abort = 1'b0;
    tag   = "reset";
    @(negedge clk);
    @(negedge clk);
    #1;
    check_now("reset_state");
    reset = 1'b1;
    idle(2);

    tag = "sel0_r1";
    burst(2'd0, 4'd1, 16'b1010, 16'b0, 16'b0, 16'b0001, 4, 1'b0);
    idle(2);

    tag = "sel1_r3";
    burst(2'd1, 4'd3, 16'b0, 16'b1110011100111, 16'b0, 16'b0010000100001, 13, 1'b0);
    idle(2);

    tag = "sel3_r1";
    burst(2'd3, 4'd1, 16'b1010, 16'b1110, 16'b1000, 16'b0001, 4, 1'b0);
    idle(2);

    tag = "reps0";
    burst(2'd2, 4'd0, 16'b0, 16'b0, 16'b10, 16'b01, 2, 1'b0);
    idle(2);

    // Abort (with start also high) in cycle 2, then a fresh start right after.
    tag = "abort";
    step(1'b1, 2'd0, 4'd2, 1'b0, 5'b10010, 1'b0);
    step(1'b0, 2'd0, 4'd2, 1'b0, 5'b00010, 1'b0);
    step(1'b1, 2'd1, 4'd2, 1'b1, 5'b00000, 1'b0);
    tag = "after_abort";
    burst(2'd2, 4'd1, 16'b0, 16'b0, 16'b10, 16'b01, 2, 1'b0);
    idle(2);

    tag = "b2b_first";
    burst(2'd0, 4'd1, 16'b1010, 16'b0, 16'b0, 16'b0001, 4, 1'b1);
    tag = "b2b_second";
    burst(2'd1, 4'd1, 16'b0, 16'b111, 16'b0, 16'b001, 3, 1'b0);
    idle(2);

    tag = "sel2_r2_expect";
    burst(2'd2, 4'd2, 16'b0, 16'b0, 16'b100010, 16'b010001, 6, 1'b0);
    idle(3);

    // Reset mid-burst: outputs drop immediately and nothing resumes after release.
    tag = "pre_reset";
    step(1'b1, 2'd3, 4'd3, 1'b0, 5'b11110, 1'b0);
    step(1'b0, 2'd3, 4'd3, 1'b0, 5'b01010, 1'b0);
    reset = 1'b0;
    #1;
    check_now("reset_mid_burst");
    m1 = 1'b0;
    m2 = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    tag = "post_reset_idle";
    idle(3);
    tag = "post_reset_start";
    burst(2'd0, 4'd1, 16'b1010, 16'b0, 16'b0, 16'b0001, 4, 1'b0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, giving the number of idle-zero cycles inserted between repetitions; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the repetition count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a burst, sampled only while busy=0.
REQ-006 SHALL have port sel, input, 2 bits: pattern select, sampled with start.
REQ-007 SHALL have port reps, input, CNT_W bits: repetition count, sampled with start.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current burst.
REQ-009 SHALL have ports x, y and z, output, 1 bit each: registered serial pattern lanes.
REQ-010 SHALL have port busy, output, 1 bit: burst in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at normal burst completion.

Function
REQ-012 SHALL emit patterns MSB-first, one bit per cycle: X lane 1010 (length 4), Y lane 111 (length 3), Z lane 10 (length 2).
REQ-013 SHALL decode sel as: 0 drives the X pattern on x only; 1 drives the Y pattern on y only; 2 drives the Z pattern on z only; 3 drives all three lanes concurrently, each zero-padded to 4 bits (y=1110, z=1000), with length 4.
REQ-014 SHALL hold unselected lanes at 0 for the whole burst.
REQ-015 SHALL implement the FSM IDLE -> SHIFT -> (GAP -> SHIFT)* -> IDLE, where IDLE waits for start, SHIFT drives pattern bits, and GAP drives zeros on all lanes for GAP_CYCLES cycles.
REQ-016 SHALL, when start=1 and busy=0 at a rising edge, assert busy and present the first pattern bit in the immediately following cycle (1-cycle latency).
REQ-017 SHALL treat reps=0 as 1.
REQ-018 SHALL insert no GAP after the final repetition.
REQ-019 SHALL keep busy high for exactly reps*L + (reps-1)*GAP_CYCLES cycles, where L is the pattern length.
REQ-020 SHALL, in the cycle after the last bit of the last repetition, deassert busy, pulse done for one cycle, and drive all lanes to 0.
REQ-021 SHALL ignore start, sel and reps while busy=1, and SHALL NOT alter the latched copies of sel and reps mid-burst.
REQ-022 SHALL, on abort=1 while busy=1, return to IDLE at the next edge with all lanes 0, busy 0 and no done pulse.
REQ-023 SHALL give abort priority over start when both are asserted in the same cycle while busy=1.
REQ-024 SHALL, when start=1 in the same cycle that done is pulsed, accept that start, so that bursts run back-to-back with no gap.
REQ-025 SHALL use saturating repetition and gap counters with no wrap-around within a burst.

Reset
REQ-026 SHALL, on reset=0, asynchronously force the FSM to IDLE and x, y, z, busy, done (and expect, when present) to 0.
REQ-027 SHALL, when reset is asserted mid-burst, discard the burst; after reset release, SHALL require a new start.

Configuration
REQ-028 SHALL, with macro SEQ_GEN_EXPECT_EN defined, add output expect (1 bit, reset 0).
REQ-029 SHALL pulse expect high for one cycle exactly two cycles after the cycle that carries the final pattern bit of each repetition, on every selected lane group (one pulse per repetition). This matches the registered-flag latency of the downstream detector.
REQ-030 SHALL, without SEQ_GEN_EXPECT_EN, omit the expect port and its logic entirely.

Structure
REQ-031 SHALL place the following in shared package seq_gen_pkg: the pattern constants (4'b1010, 3'b111, 2'b10), pattern lengths, the sel encoding constants, and the FSM state typedef.
REQ-032 SHALL instantiate sub-module seq_gen_lane three times; each instance is a loadable 4-bit MSB-first shift register with clear.

Verification
REQ-033 SHALL cover: sel=0, reps=1 -> x = 1,0,1,0 over cycles 1-4; busy high 4 cycles; done in cycle 5; y=z=0.
REQ-034 SHALL cover: sel=1, reps=3, GAP_CYCLES=2 -> y = 111 00 111 00 111; busy high 13 cycles; single done pulse.
REQ-035 SHALL cover: sel=3, reps=1 -> x,y,z = 1010/1110/1000 in parallel; busy high 4 cycles.
REQ-036 SHALL cover: abort in cycle 2 of sel=0, reps=2 -> lanes 0 and busy 0 next cycle; no done; a new start is accepted one cycle later.
REQ-037 SHALL cover: start held high across done -> second burst starts in the done cycle +1; reset=0 mid-burst -> all outputs 0 immediately.
REQ-038 SHALL cover, with SEQ_GEN_EXPECT_EN defined: sel=2, reps=2 -> expect pulses exactly 2 cycles after each final 0 bit of z.
